// File: rtl/multicycle_ctrl.sv
// Multicycle controller for an LEGv8-style datapath.
// Moore-style decode of datapath controls from the current state.
// Outputs depend on MEM_READY only in FETCH and MEM_WR, and on ZERO only in CBZ_EXEC.
// DECODE also looks at OPCODE to flag illegal instructions.
module multicycle_ctrl (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic [10:0] OPCODE,
   input  logic        ZERO,
   input  logic        MEM_READY,
   output logic        PC_WRITE,
   output logic        PC_SOURCE,
   output logic        IR_WRITE,
   output logic        MEM_READ,
   output logic        MEM_WRITE,
   output logic        IORD,
   output logic        REG_WRITE,
   output logic        MEM_TO_REG,
   output logic        ALU_SRC_A,
   output logic [1:0]  ALU_SRC_B,
   output logic [1:0]  ALU_OP,
   output logic        INSTR_DONE,
   output logic        ILLEGAL,
   output logic [3:0]  STATE
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEM_ADDR = 4'd2,
      S_MEM_RD   = 4'd3,
      S_LD_WB    = 4'd4,
      S_MEM_WR   = 4'd5,
      S_R_EXEC   = 4'd6,
      S_R_WB     = 4'd7,
      S_CBZ_EXEC = 4'd8,
      S_B_EXEC   = 4'd9
   } state_t;

   state_t state, state_nxt;

   // MEM_READY is masked while reset is held, so the FETCH decode that is
   // visible during reset never fires IR_WRITE or PC_WRITE.
   logic rdy;
   assign rdy = MEM_READY & RST_N;

   // Opcode classes.
   logic is_rtype, is_ldur, is_stur, is_cbz, is_b;
   assign is_rtype = (OPCODE == 11'b10001011000) || (OPCODE == 11'b11001011000) ||
                     (OPCODE == 11'b10001010000) || (OPCODE == 11'b10101010000);
   assign is_ldur  = (OPCODE == 11'b11111000010);
   assign is_stur  = (OPCODE == 11'b11111000000);
   assign is_cbz   = (OPCODE[10:3] == 8'b10110100);
   assign is_b     = (OPCODE[10:5] == 6'b000101);

   assign STATE = state;

   // State register; reset forces FETCH asynchronously.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state <= S_FETCH;
      else        state <= state_nxt;
   end

   // Next-state and control decode.
   always_comb begin
      state_nxt  = S_FETCH;
      PC_WRITE   = 1'b0;
      PC_SOURCE  = 1'b0;
      IR_WRITE   = 1'b0;
      MEM_READ   = 1'b0;
      MEM_WRITE  = 1'b0;
      IORD       = 1'b0;
      REG_WRITE  = 1'b0;
      MEM_TO_REG = 1'b0;
      ALU_SRC_A  = 1'b0;
      ALU_SRC_B  = 2'b00;
      ALU_OP     = 2'b00;
      INSTR_DONE = 1'b0;
      ILLEGAL    = 1'b0;
      case (state)
         S_FETCH: begin
            MEM_READ  = 1'b1;
            ALU_SRC_B = 2'b01;              // PC + 4
            IR_WRITE  = rdy;
            PC_WRITE  = rdy;
            state_nxt = rdy ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            ALU_SRC_B = 2'b11;              // branch target into ALUOut
            if (is_rtype)               state_nxt = S_R_EXEC;
            else if (is_ldur || is_stur) state_nxt = S_MEM_ADDR;
            else if (is_cbz)            state_nxt = S_CBZ_EXEC;
            else if (is_b)              state_nxt = S_B_EXEC;
            else begin
               state_nxt  = S_FETCH;
               ILLEGAL    = 1'b1;
               INSTR_DONE = 1'b1;
            end
         end
         S_MEM_ADDR: begin
            ALU_SRC_A = 1'b1;
            ALU_SRC_B = 2'b10;
            if (is_ldur)      state_nxt = S_MEM_RD;
            else if (is_stur) state_nxt = S_MEM_WR;
            else              state_nxt = S_FETCH;
         end
         S_MEM_RD: begin
            MEM_READ  = 1'b1;
            IORD      = 1'b1;
            state_nxt = MEM_READY ? S_LD_WB : S_MEM_RD;
         end
         S_LD_WB: begin
            REG_WRITE  = 1'b1;
            MEM_TO_REG = 1'b1;
            INSTR_DONE = 1'b1;
         end
         S_MEM_WR: begin
            MEM_WRITE  = 1'b1;
            IORD       = 1'b1;
            INSTR_DONE = MEM_READY;
            state_nxt  = MEM_READY ? S_FETCH : S_MEM_WR;
         end
         S_R_EXEC: begin
            ALU_SRC_A = 1'b1;
            ALU_OP    = 2'b10;
            state_nxt = S_R_WB;
         end
         S_R_WB: begin
            REG_WRITE  = 1'b1;
            INSTR_DONE = 1'b1;
         end
         S_CBZ_EXEC: begin
            ALU_SRC_A  = 1'b1;
            ALU_OP     = 2'b01;
            PC_SOURCE  = 1'b1;
            PC_WRITE   = ZERO;
            INSTR_DONE = 1'b1;
         end
         S_B_EXEC: begin
            PC_SOURCE  = 1'b1;
            PC_WRITE   = 1'b1;
            INSTR_DONE = 1'b1;
         end
         default: state_nxt = S_FETCH;  // unused encodings recover
      endcase
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized and directed bench for multicycle_ctrl against a per-instruction
// state-trace model and a state-to-controls table.
module tb_multicycle_ctrl;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic [10:0] OPCODE = '0;
   logic        ZERO = 1'b0;
   logic        MEM_READY = 1'b0;
   logic        PC_WRITE, PC_SOURCE, IR_WRITE, MEM_READ, MEM_WRITE, IORD;
   logic        REG_WRITE, MEM_TO_REG, ALU_SRC_A, INSTR_DONE, ILLEGAL;
   logic [1:0]  ALU_SRC_B, ALU_OP;
   logic [3:0]  STATE;

   int total = 0;
   int bad = 0;
   int done_cnt = 0;

   multicycle_ctrl dut (
      .CLK(CLK), .RST_N(RST_N), .OPCODE(OPCODE), .ZERO(ZERO), .MEM_READY(MEM_READY),
      .PC_WRITE(PC_WRITE), .PC_SOURCE(PC_SOURCE), .IR_WRITE(IR_WRITE),
      .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .IORD(IORD),
      .REG_WRITE(REG_WRITE), .MEM_TO_REG(MEM_TO_REG), .ALU_SRC_A(ALU_SRC_A),
      .ALU_SRC_B(ALU_SRC_B), .ALU_OP(ALU_OP), .INSTR_DONE(INSTR_DONE),
      .ILLEGAL(ILLEGAL), .STATE(STATE)
   );

   always #5 CLK = ~CLK;

   localparam logic [10:0] OP_ADD  = 11'b10001011000;
   localparam logic [10:0] OP_SUB  = 11'b11001011000;
   localparam logic [10:0] OP_AND  = 11'b10001010000;
   localparam logic [10:0] OP_ORR  = 11'b10101010000;
   localparam logic [10:0] OP_LDUR = 11'b11111000010;
   localparam logic [10:0] OP_STUR = 11'b11111000000;

   // Instruction class: 0 R-type, 1 LDUR, 2 STUR, 3 CBZ, 4 B, 5 illegal.
   function automatic int cls(input logic [10:0] op);
      if (op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_ORR) return 0;
      if (op == OP_LDUR) return 1;
      if (op == OP_STUR) return 2;
      if (op[10:3] == 8'b10110100) return 3;
      if (op[10:5] == 6'b000101) return 4;
      return 5;
   endfunction

   // Required controls for a state:
   // {pcw,pcs,irw,mr,mw,iord,rw,m2r,asa,asb[1:0],aop[1:0],done,ill}
   function automatic logic [14:0] exp_out(input int st, input logic [10:0] op,
                                           input logic rdy, input logic z);
      logic pcw, pcs, irw, mr, mw, iord, rw, m2r, asa, done, ill;
      logic [1:0] asb, aop;
      {pcw, pcs, irw, mr, mw, iord, rw, m2r, asa, done, ill} = '0;
      asb = 2'b00; aop = 2'b00;
      case (st)
         0: begin mr = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
         1: begin asb = 2'b11; if (cls(op) == 5) begin ill = 1; done = 1; end end
         2: begin asa = 1; asb = 2'b10; end
         3: begin mr = 1; iord = 1; end
         4: begin rw = 1; m2r = 1; done = 1; end
         5: begin mw = 1; iord = 1; done = rdy; end
         6: begin asa = 1; aop = 2'b10; end
         7: begin rw = 1; done = 1; end
         8: begin asa = 1; aop = 2'b01; pcs = 1; pcw = z; done = 1; end
         9: begin pcs = 1; pcw = 1; done = 1; end
         default: ;
      endcase
      return {pcw, pcs, irw, mr, mw, iord, rw, m2r, asa, asb, aop, done, ill};
   endfunction

   function automatic logic [14:0] dut_out();
      return {PC_WRITE, PC_SOURCE, IR_WRITE, MEM_READ, MEM_WRITE, IORD, REG_WRITE,
              MEM_TO_REG, ALU_SRC_A, ALU_SRC_B, ALU_OP, INSTR_DONE, ILLEGAL};
   endfunction

   // One clock cycle: drive inputs, check mid-cycle, advance past the edge.
   task automatic step(input string tag, input int st, input logic rdy, input logic z);
      logic [14:0] e;
      MEM_READY = rdy;
      ZERO = z;
      @(negedge CLK);
      e = exp_out(st, OPCODE, rdy, z);
      total++;
      assert (STATE === 4'(st)) else begin
         bad++; $error("FAIL %s state: got %0d want %0d", tag, STATE, st);
      end
      total++;
      assert (dut_out() === e) else begin
         bad++; $error("FAIL %s ctrl st=%0d: got %b want %b", tag, st, dut_out(), e);
      end
      total++;
      assert (!(MEM_READ && MEM_WRITE) && !(REG_WRITE && PC_WRITE)) else begin
         bad++; $error("FAIL %s exclusive: mr=%b mw=%b rw=%b pcw=%b want no overlap",
                       tag, MEM_READ, MEM_WRITE, REG_WRITE, PC_WRITE);
      end
      if (INSTR_DONE === 1'b1) done_cnt++;
      @(posedge CLK);
      #1;
   endtask

   // Build the expected state trace for one instruction and walk it.
   // zmode: 0 random ZERO, 1 force ZERO=1, 2 force ZERO=0.
   task automatic run_instr(input string tag, input logic [10:0] op,
                            input int fw, input int mw, input int zmode);
      int   sts[$];
      logic rds[$];
      int   c;
      logic z;
      OPCODE = op;
      c = cls(op);
      for (int i = 0; i < fw; i++) begin sts.push_back(0); rds.push_back(1'b0); end
      sts.push_back(0); rds.push_back(1'b1);
      sts.push_back(1); rds.push_back(1'($urandom_range(0, 1)));
      case (c)
         0: begin sts.push_back(6); rds.push_back(1'b1); sts.push_back(7); rds.push_back(1'b0); end
         1: begin
            sts.push_back(2); rds.push_back(1'b0);
            for (int i = 0; i < mw; i++) begin sts.push_back(3); rds.push_back(1'b0); end
            sts.push_back(3); rds.push_back(1'b1);
            sts.push_back(4); rds.push_back(1'($urandom_range(0, 1)));
         end
         2: begin
            sts.push_back(2); rds.push_back(1'b1);
            for (int i = 0; i < mw; i++) begin sts.push_back(5); rds.push_back(1'b0); end
            sts.push_back(5); rds.push_back(1'b1);
         end
         3: begin sts.push_back(8); rds.push_back(1'($urandom_range(0, 1))); end
         4: begin sts.push_back(9); rds.push_back(1'($urandom_range(0, 1))); end
         default: ;
      endcase
      done_cnt = 0;
      foreach (sts[i]) begin
         z = (zmode == 1) ? 1'b1 : (zmode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
         step(tag, sts[i], rds[i], z);
      end
      total++;
      assert (done_cnt == 1) else begin
         bad++; $error("FAIL %s done_count: got %0d want 1", tag, done_cnt);
      end
   endtask

   initial begin
      logic [10:0] op;
      int          k;

      // Reset held: FETCH decode with MEM_READY masked.
      MEM_READY = 1'b1;
      #12;
      total++;
      assert (STATE === 4'd0) else begin
         bad++; $error("FAIL reset_state: got %0d want 0", STATE);
      end
      total++;
      assert (dut_out() === exp_out(0, OPCODE, 1'b0, 1'b0)) else begin
         bad++; $error("FAIL reset_ctrl: got %b want %b", dut_out(), exp_out(0, OPCODE, 1'b0, 1'b0));
      end
      @(posedge CLK);
      #1;
      RST_N = 1'b1;

      // Directed cases.
      run_instr("add", OP_ADD, 0, 0, 0);
      run_instr("ldur_wait2", OP_LDUR, 0, 2, 0);
      run_instr("stur", OP_STUR, 1, 1, 0);
      run_instr("cbz_z1", 11'b10110100101, 0, 0, 1);
      run_instr("cbz_z0", 11'b10110100011, 0, 0, 2);
      run_instr("b", 11'b00010110110, 0, 0, 0);
      run_instr("illegal", 11'b11111111111, 0, 0, 0);

      // Async reset in MEM_WR while memory stalls.
      OPCODE = OP_STUR;
      step("rst_pre", 0, 1'b1, 1'b0);
      step("rst_pre", 1, 1'b1, 1'b0);
      step("rst_pre", 2, 1'b1, 1'b0);
      MEM_READY = 1'b0;
      @(negedge CLK);
      total++;
      assert (STATE === 4'd5 && MEM_WRITE === 1'b1) else begin
         bad++; $error("FAIL rst_memwr: state %0d mw %b want 5 1", STATE, MEM_WRITE);
      end
      #2 RST_N = 1'b0;
      #1;
      total++;
      assert (STATE === 4'd0 && MEM_WRITE === 1'b0) else begin
         bad++; $error("FAIL rst_async: state %0d mw %b want 0 0", STATE, MEM_WRITE);
      end
      MEM_READY = 1'b1;
      #1;
      total++;
      assert ({IR_WRITE, PC_WRITE, REG_WRITE, MEM_WRITE} === 4'b0000) else begin
         bad++; $error("FAIL rst_mask: irw/pcw/rw/mw %b want 0000",
                       {IR_WRITE, PC_WRITE, REG_WRITE, MEM_WRITE});
      end
      @(posedge CLK);
      #1;
      total++;
      assert (STATE === 4'd0) else begin
         bad++; $error("FAIL rst_hold: got %0d want 0", STATE);
      end
      RST_N = 1'b1;
      run_instr("post_rst", OP_ADD, 1, 0, 0);

      // Random stream with random stalls.
      for (int n = 0; n < 80; n++) begin
         k = $urandom_range(0, 8);
         case (k)
            0: op = OP_ADD;
            1: op = OP_SUB;
            2: op = OP_AND;
            3: op = OP_ORR;
            4: op = OP_LDUR;
            5: op = OP_STUR;
            6: op = {8'b10110100, 3'($urandom_range(0, 7))};
            7: op = {6'b000101, 5'($urandom_range(0, 31))};
            default: op = 11'($urandom_range(0, 2047));
         endcase
         run_instr("rand", op, $urandom_range(0, 2), $urandom_range(0, 3), 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
